// File: rtl/pcie_perst_link_ctrl_pkg.sv
// Shared state encoding for the PERST_n/link-presence controller and any monitor
// that decodes its STATE output.
package pcie_perst_pkg;

    localparam logic [2:0] STATE_HOLD   = 3'd0;
    localparam logic [2:0] STATE_DETECT = 3'd1;
    localparam logic [2:0] STATE_UP     = 3'd2;
    localparam logic [2:0] STATE_FAIL   = 3'd3;

    typedef enum logic [2:0] {
        ST_HOLD   = STATE_HOLD,
        ST_DETECT = STATE_DETECT,
        ST_UP     = STATE_UP,
        ST_FAIL   = STATE_FAIL
    } link_state_t;

endpackage

// File: rtl/pcie_lane_activity_det.sv
// Per-lane differential activity decode with saturating active/idle streak counters.
// A cycle is active only when every lane shows a clean complementary pair.
module pcie_lane_activity_det #(
    parameter int LANES          = 1,
    parameter int ACTIVE_MIN_CYC = 16,
    parameter int IDLE_LOSS_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [LANES-1:0] rx,
    input  logic [LANES-1:0] rx_n,
    output logic             active_ok,
    output logic             idle_loss
);

    localparam int AW = $clog2(ACTIVE_MIN_CYC + 1);
    localparam int IW = $clog2(IDLE_LOSS_CYC + 1);

    localparam logic [AW-1:0] ACT_LAST  = AW'(ACTIVE_MIN_CYC - 1);
    localparam logic [AW-1:0] ACT_MAX   = AW'(ACTIVE_MIN_CYC);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LOSS_CYC - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_LOSS_CYC);

    logic [LANES-1:0] lane_act;
    logic             active;
    logic [AW-1:0]    act_streak;
    logic [IW-1:0]    idle_streak;

    // Equal legs or unknown levels both count as electrical idle on that lane.
    always_comb begin
        lane_act = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_act[i] = ((rx[i] ^ rx_n[i]) === 1'b1);
        end
    end

    assign active    = &lane_act;
    assign active_ok = active && (act_streak == ACT_LAST);
    assign idle_loss = !active && (idle_streak == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_streak  <= '0;
            idle_streak <= '0;
        end else if (clr) begin
            act_streak  <= '0;
            idle_streak <= '0;
        end else if (active) begin
            act_streak  <= (act_streak == ACT_MAX) ? ACT_MAX : act_streak + 1'b1;
            idle_streak <= '0;
        end else begin
            act_streak  <= '0;
            idle_streak <= (idle_streak == IDLE_MAX) ? IDLE_MAX : idle_streak + 1'b1;
        end
    end

endmodule

// File: rtl/pcie_perst_link_ctrl.sv
// Root-port PERST_n sequencer: holds the device in reset after power-good, then
// watches the lanes for activity and reports link-up, link loss or detect failure.
module pcie_perst_link_ctrl
    import pcie_perst_pkg::*;
#(
    parameter int linkWidth          = 1,
    parameter int PERST_HOLD_CYC     = 1000,
    parameter int DETECT_TIMEOUT_CYC = 20000,
    parameter int ACTIVE_MIN_CYC     = 16,
    parameter int IDLE_LOSS_CYC      = 64,
    parameter int MAX_RETRIES        = 3
) (
    input  logic                               CLK,
    input  logic                               RST_n,
    input  logic                               PWR_GOOD,
    input  logic                               SW_RESET_REQ,
    input  logic [linkWidth-1:0]               RX,
    input  logic [linkWidth-1:0]               RX_,
    output logic                               PERST_n,
    output logic                               LINK_UP,
    output logic                               LINK_FAIL,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   RETRY_CNT,
    output logic [2:0]                         STATE
);

    localparam int HW = $clog2(PERST_HOLD_CYC + 1);
    localparam int TW = $clog2(DETECT_TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(PERST_HOLD_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(PERST_HOLD_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DETECT_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(DETECT_TIMEOUT_CYC);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    link_state_t   state;
    link_state_t   state_next;
    logic [1:0]    rst_sync;
    logic          rst_ok;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_next;
    logic          enter;
    logic          active_ok;
    logic          idle_loss;

    pcie_lane_activity_det #(
        .LANES          (linkWidth),
        .ACTIVE_MIN_CYC (ACTIVE_MIN_CYC),
        .IDLE_LOSS_CYC  (IDLE_LOSS_CYC)
    ) u_activity (
        .clk       (CLK),
        .rst_n     (RST_n),
        .clr       (enter),
        .rx        (RX),
        .rx_n      (RX_),
        .active_ok (active_ok),
        .idle_loss (idle_loss)
    );

    // Reset release is retimed so the hold count never starts on a metastable edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_ok = rst_sync[1];

    always_comb begin
        state_next = state;
        retry_next = RETRY_CNT;
        enter      = 1'b0;
        if (SW_RESET_REQ) begin
            state_next = ST_HOLD;
            retry_next = '0;
            enter      = 1'b1;
        end else if (!PWR_GOOD && (state == ST_DETECT || state == ST_UP)) begin
            state_next = ST_HOLD;
            enter      = 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (rst_ok && PWR_GOOD && hold_cnt == HOLD_LAST) begin
                        state_next = ST_DETECT;
                        enter      = 1'b1;
                    end
                end
                ST_DETECT: begin
                    // A completing streak beats a timeout landing on the same edge.
                    if (active_ok) begin
                        state_next = ST_UP;
                        enter      = 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        enter = 1'b1;
                        if (RETRY_CNT != RETRY_MAX) begin
                            state_next = ST_HOLD;
                            retry_next = RETRY_CNT + 1'b1;
                        end else begin
                            state_next = ST_FAIL;
                        end
                    end
                end
                ST_UP: begin
                    if (idle_loss) begin
                        state_next = ST_HOLD;
                        retry_next = '0;
                        enter      = 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_HOLD;
                    enter      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            hold_cnt <= '0;
            timer    <= '0;
        end else if (enter) begin
            hold_cnt <= '0;
            timer    <= '0;
        end else begin
            if (state == ST_HOLD && PWR_GOOD && rst_ok) begin
                hold_cnt <= (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
            if (state == ST_DETECT) begin
                timer <= (timer == TIMER_MAX) ? TIMER_MAX : timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

    // Outputs decode the next state so they move on the same edge as the transition.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= ST_HOLD;
            PERST_n   <= 1'b0;
            LINK_UP   <= 1'b0;
            LINK_FAIL <= 1'b0;
            RETRY_CNT <= '0;
        end else begin
            state     <= state_next;
            PERST_n   <= (state_next == ST_DETECT) || (state_next == ST_UP);
            LINK_UP   <= (state_next == ST_UP);
            LINK_FAIL <= (state_next == ST_FAIL);
            RETRY_CNT <= retry_next;
        end
    end

    assign STATE = state;

endmodule

// File: doc/pcie_perst_link_ctrl.md
# pcie_perst_link_ctrl

Root-port-side reset and link-presence controller: the upstream end of the PERST_n/serial-lane interface presented by the PCIe device BFM. It drives PERST_n to the device and holds it for a programmed minimum after power is good. It then watches the device's TX differential pairs, arriving here as RX/RX_, for electrical activity and reports link-up, link loss or detect failure with bounded retries. It sits in the testbench/host harness between the power model and the device BFM.

## Interface
Parameters:
- linkWidth, 1, number of lanes monitored
- PERST_HOLD_CYC, 1000, cycles PERST_n held low after PWR_GOOD is sampled high
- DETECT_TIMEOUT_CYC, 20000, maximum cycles in DETECT before a retry
- ACTIVE_MIN_CYC, 16, consecutive active cycles required to declare link-up
- IDLE_LOSS_CYC, 64, consecutive idle cycles in UP that declare link loss
- MAX_RETRIES, 3, detect retries before FAIL

Ports:
- CLK  input  1  sole clock, rising edge
- RST_n  input  1  asynchronous active-low reset
- PWR_GOOD  input  1  supply-stable indication, level
- SW_RESET_REQ  input  1  single-cycle request to restart the sequence
- RX  input  linkWidth  positive legs of the device TX pairs
- RX_  input  linkWidth  negative legs of the device TX pairs
- PERST_n  output  1  fundamental reset to the device, registered
- LINK_UP  output  1  link present, registered
- LINK_FAIL  output  1  retries exhausted, sticky until restart
- RETRY_CNT  output  $clog2(MAX_RETRIES+1)  detect timeouts in the current sequence
- STATE  output  3  current FSM state encoding

## Operation
- Cycle active: every lane i has (RX[i] ^ RX_[i]) === 1. Any lane equal or X/Z makes the cycle idle.
- States: HOLD=0, DETECT=1, UP=2, FAIL=3.
- HOLD: PERST_n=0. The hold counter increments each cycle PWR_GOOD=1 and clears when PWR_GOOD=0. When it reaches PERST_HOLD_CYC, the FSM goes to DETECT.
- DETECT: PERST_n=1. The timer counts from 0. The active-streak counter increments on active cycles and clears on idle cycles.
  - Streak reaches ACTIVE_MIN_CYC: go to UP.
  - Timer reaches DETECT_TIMEOUT_CYC with RETRY_CNT<MAX_RETRIES: RETRY_CNT+1, go to HOLD.
  - Same timeout with RETRY_CNT==MAX_RETRIES: go to FAIL.
- UP: PERST_n=1, LINK_UP=1. The idle-streak counter clears on any active cycle. Reaching IDLE_LOSS_CYC goes to HOLD and clears RETRY_CNT.
- FAIL: PERST_n=0, LINK_FAIL=1. The FSM leaves FAIL only through SW_RESET_REQ or RST_n.
- Priority, highest first: RST_n; SW_RESET_REQ (go to HOLD, clear RETRY_CNT and LINK_FAIL, from any state); PWR_GOOD=0 (from DETECT/UP go to HOLD, RETRY_CNT kept); normal transitions.
- Link completion and timeout on the same edge: completion wins.
- All counters clear on every state entry.
- Counters saturate and never wrap. Widths are sized with $clog2 of their parameter +1.

## Timing
- Reset values: PERST_n=0, LINK_UP=0, LINK_FAIL=0, RETRY_CNT=0, STATE=HOLD. All counters are 0.
- All outputs are registered and are decoded from the next-state value, so an output changes on the same edge as the transition that causes it.
- PWR_GOOD first sampled high at edge k, and held high: PERST_n rises at edge k+PERST_HOLD_CYC-1.
- LINK_UP rises on the edge that samples the ACTIVE_MIN_CYC-th consecutive active cycle.
- LINK_UP falls on the edge that samples the IDLE_LOSS_CYC-th idle cycle. PERST_n falls on that same edge.
- SW_RESET_REQ or PWR_GOOD drop sampled at edge n: PERST_n=0 and LINK_UP=0 after edge n.
- RST_n assertion forces reset values immediately. Deassertion is synchronised internally by 2 flops before the FSM leaves HOLD.

## Structure
- Package pcie_perst_pkg holds the state enum (HOLD/DETECT/UP/FAIL, 3-bit) and the STATE encoding constants, which are shared with monitors.
- One sub-module, pcie_lane_activity_det, contains:
  - per-lane active decode and the AND across lanes;
  - active-streak and idle-streak counters;
  - `active_ok` and `idle_loss` pulses.
- The FSM, hold counter, timeout timer and retry counter live in the top module.

## Test plan
Parameters for all scenarios: PERST_HOLD_CYC=10, DETECT_TIMEOUT_CYC=50, ACTIVE_MIN_CYC=4, IDLE_LOSS_CYC=8, MAX_RETRIES=2.
- PWR_GOOD high at edge 5, lanes driven differentially from cycle 20 → PERST_n rises after edge 14 and LINK_UP rises after edge 23.
- PWR_GOOD toggles low for 1 cycle at hold count 7 → hold count restarts, and PERST_n rises 10 cycles after PWR_GOOD returns high.
- Lanes stay idle → 2 retries with RETRY_CNT 1 then 2, then FAIL with LINK_FAIL=1 and PERST_n=0. SW_RESET_REQ then returns to HOLD with RETRY_CNT=0 and LINK_FAIL=0.
- In UP, lanes idle for 7 cycles, active for 1, then idle for 8 → LINK_UP holds through the 7-cycle gap and drops on the 8th idle edge of the second gap, with PERST_n=0.
- linkWidth=4, lane 2 driven RX==RX_ while lanes 0, 1 and 3 are active → no LINK_UP and timeout retry at timer 50.
- 4th active sample and timeout on the same edge → LINK_UP=1 and RETRY_CNT unchanged. RST_n pulsed low mid-DETECT → immediate reset values.
